// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Moore main-control FSM for the multicycle RV32I core. One instruction is
// sequenced over 3..5 states (plus memory wait states). All datapath selects
// are decoded from the current state only; mem_ready and zero gate only the
// FETCH ir_write/pc_update strobes, the state-advance conditions, and the BEQ
// pc_write.
//
// Supported: lw, sw, R-type, I-type ALU, beq, jal.
//
// Optional feature (compile-time macro MC_ILLEGAL_OP_EN):
//   defined   : an unknown opcode in DECODE enters TRAP (encoding 12), which
//               holds until reset. While in TRAP illegal_op=1 and every other
//               output is 0, so the flag is sticky until rst_n asserts.
//   undefined : an unknown opcode is executed as a NOP (DECODE -> FETCH),
//               illegal_op is tied 0 and encoding 12 is unused.
//
// Parameters
//   STATE_W     width of dbg_state; must be >= 4
//
// Ports
//   clk         in   core clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   op[6:0]     in   instr[6:0] from the instruction register
//   zero        in   ALU zero flag, meaningful in BEQ
//   mem_ready   in   memory access completes this cycle
//   pc_write    out  PC enable = pc_update | (branch & zero)
//   adr_src     out  0: address = PC, 1: address = result
//   mem_write   out  data memory write strobe
//   ir_write    out  IR / OldPC load enable
//   reg_write   out  register file write enable
//   result_src  out  00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a   out  00 PC, 01 OldPC, 10 RD1
//   alu_src_b   out  00 RD2, 01 ImmExt, 10 constant 4
//   alu_op      out  00 add, 01 sub, 10 funct-decoded
//   illegal_op  out  sticky illegal-opcode flag
//   dbg_state   out  current state encoding, zero-extended to STATE_W
// ----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  // State encodings are architecturally visible through dbg_state.
  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  state_e state_q;
  state_e state_d;

  logic pc_update;
  logic branch;

  // --------------------------------------------------------------------------
  // State register. Asynchronous reset abandons any in-flight instruction;
  // because every strobe is decoded from state, writes stop at once.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. op is only looked at in DECODE and MEMADR.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_OP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      // lw and sw differ only in op[5].
      S_MEMADR: state_d = op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      // jal still has to write PC+4 into rd, which ALUWB does from ALUOut.
      S_JAL:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_OP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      // Unreachable encodings recover through the reset state.
      default:  state_d = S_RST;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore). Every output defaults to 0.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC while the IR loads.
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        // Branch target OldPC+imm lands in ALUOut for BEQ to use.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        // ALU computes rs1-rs2 for the zero flag; PC takes ALUOut target.
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      S_JAL: begin
        // PC <- ALUOut (jump target from DECODE) while ALU forms OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
`ifdef MC_ILLEGAL_OP_EN
      S_TRAP: begin
        // TRAP is left only through reset, which makes the flag sticky.
        illegal_op = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign pc_write = pc_update | (branch & zero);

  always_comb begin
    dbg_state      = '0;
    dbg_state[3:0] = state_q;
  end

`ifndef SYNTHESIS
  // Structural invariants of the decode table.
  a_store_uses_result_adr : assert property (@(posedge clk) disable iff (!rst_n)
    mem_write |-> adr_src);
  a_no_write_conflict : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_write && reg_write));
  a_ir_only_in_fetch : assert property (@(posedge clk) disable iff (!rst_n)
    ir_write |-> (state_q == S_FETCH));
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int STATE_W = 4;

  logic               clk;
  logic               rst_n;
  logic [6:0]         op;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               illegal_op;
  logic [STATE_W-1:0] dbg_state;

  int total;
  int passed;

  multicycle_controller #(.STATE_W(STATE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: pcw adr mw irw rw rs[1:0] sa[1:0] sb[1:0] aop[1:0] ill
  logic [13:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

  function automatic logic [13:0] ev(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ill};
  endfunction

  logic [13:0] E_RST, E_FETCH, E_FWAIT, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
  logic [13:0] E_MEMWR, E_EXECR, E_EXECI, E_ALUWB, E_BEQ1, E_BEQ0, E_JAL, E_TRAP;

  // Advance to the next negedge, then let combinational outputs settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (outs !== E_RST || dbg_state !== 4'd0) $display("FAIL reset_held: outs=%b st=%0d expected outs=%b st=0", outs, dbg_state, E_RST);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (outs !== E_RST || dbg_state !== 4'd0) $display("FAIL reset_cycle0: outs=%b st=%0d expected outs=%b st=0", outs, dbg_state, E_RST);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL reset_cycle1_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  // Each following task starts in FETCH with mem_ready=1.
  task automatic test_rtype();
    op = 7'b0110011;
    tick();
    total++;
    if (outs !== E_DECODE || dbg_state !== 4'd2) $display("FAIL rtype_decode: outs=%b st=%0d expected outs=%b st=2", outs, dbg_state, E_DECODE);
    else passed++;
    tick();
    total++;
    if (outs !== E_EXECR || dbg_state !== 4'd7) $display("FAIL rtype_execr: outs=%b st=%0d expected outs=%b st=7", outs, dbg_state, E_EXECR);
    else passed++;
    op = 7'b1100011;  // must be ignored outside DECODE/MEMADR
    tick();
    total++;
    if (outs !== E_ALUWB || dbg_state !== 4'd9) $display("FAIL rtype_aluwb: outs=%b st=%0d expected outs=%b st=9", outs, dbg_state, E_ALUWB);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL rtype_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_itype();
    op = 7'b0010011;
    tick();
    tick();
    total++;
    if (outs !== E_EXECI || dbg_state !== 4'd8) $display("FAIL itype_execi: outs=%b st=%0d expected outs=%b st=8", outs, dbg_state, E_EXECI);
    else passed++;
    tick();
    total++;
    if (outs !== E_ALUWB || dbg_state !== 4'd9) $display("FAIL itype_aluwb: outs=%b st=%0d expected outs=%b st=9", outs, dbg_state, E_ALUWB);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL itype_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_load_wait();
    op = 7'b0000011;
    tick();
    tick();
    total++;
    if (outs !== E_MEMADR || dbg_state !== 4'd3) $display("FAIL lw_memadr: outs=%b st=%0d expected outs=%b st=3", outs, dbg_state, E_MEMADR);
    else passed++;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs !== E_MEMRD || dbg_state !== 4'd4) $display("FAIL lw_memrd_hold%0d: outs=%b st=%0d expected outs=%b st=4", i, outs, dbg_state, E_MEMRD);
      else passed++;
      if (i == 2) mem_ready = 1'b1;
    end
    tick();
    total++;
    if (outs !== E_MEMWB || dbg_state !== 4'd5) $display("FAIL lw_memwb: outs=%b st=%0d expected outs=%b st=5", outs, dbg_state, E_MEMWB);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL lw_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_store_wait();
    mem_ready = 1'b0;
    #1;
    total++;
    if (outs !== E_FWAIT || dbg_state !== 4'd1) $display("FAIL fetch_wait_strobes: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FWAIT);
    else passed++;
    tick();
    total++;
    if (outs !== E_FWAIT || dbg_state !== 4'd1) $display("FAIL fetch_wait_hold: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FWAIT);
    else passed++;
    mem_ready = 1'b1;
    op = 7'b0100011;
    #1;
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL fetch_ready_strobes: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
    tick();
    tick();
    total++;
    if (outs !== E_MEMADR || dbg_state !== 4'd3) $display("FAIL sw_memadr: outs=%b st=%0d expected outs=%b st=3", outs, dbg_state, E_MEMADR);
    else passed++;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outs !== E_MEMWR || dbg_state !== 4'd6) $display("FAIL sw_memwr_hold%0d: outs=%b st=%0d expected outs=%b st=6", i, outs, dbg_state, E_MEMWR);
      else passed++;
    end
    mem_ready = 1'b1;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL sw_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_beq();
    op = 7'b1100011;
    zero = 1'b1;
    tick();
    tick();
    total++;
    if (outs !== E_BEQ1 || dbg_state !== 4'd10) $display("FAIL beq_taken: outs=%b st=%0d expected outs=%b st=10", outs, dbg_state, E_BEQ1);
    else passed++;
    zero = 1'b0;
    #1;
    total++;
    if (outs !== E_BEQ0) $display("FAIL beq_zero_same_cycle: outs=%b expected outs=%b", outs, E_BEQ0);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL beq_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
    tick();
    tick();
    total++;
    if (outs !== E_BEQ0 || dbg_state !== 4'd10) $display("FAIL beq_not_taken: outs=%b st=%0d expected outs=%b st=10", outs, dbg_state, E_BEQ0);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL beq2_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_jal();
    op = 7'b1101111;
    tick();
    tick();
    total++;
    if (outs !== E_JAL || dbg_state !== 4'd11) $display("FAIL jal_state: outs=%b st=%0d expected outs=%b st=11", outs, dbg_state, E_JAL);
    else passed++;
    tick();
    total++;
    if (outs !== E_ALUWB || dbg_state !== 4'd9) $display("FAIL jal_aluwb: outs=%b st=%0d expected outs=%b st=9", outs, dbg_state, E_ALUWB);
    else passed++;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL jal_back_to_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    tick();
    total++;
    if (outs !== E_DECODE || dbg_state !== 4'd2) $display("FAIL illegal_decode: outs=%b st=%0d expected outs=%b st=2", outs, dbg_state, E_DECODE);
    else passed++;
`ifdef MC_ILLEGAL_OP_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (outs !== E_TRAP || dbg_state !== 4'd12) $display("FAIL trap_hold%0d: outs=%b st=%0d expected outs=%b st=12", i, outs, dbg_state, E_TRAP);
      else passed++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== E_RST || dbg_state !== 4'd0) $display("FAIL trap_reset_clears: outs=%b st=%0d expected outs=%b st=0", outs, dbg_state, E_RST);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL trap_recover_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
`else
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL illegal_nop_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_memwr();
    op = 7'b0100011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    total++;
    if (outs !== E_MEMWR || dbg_state !== 4'd6) $display("FAIL midrst_memwr: outs=%b st=%0d expected outs=%b st=6", outs, dbg_state, E_MEMWR);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== E_RST || dbg_state !== 4'd0) $display("FAIL midrst_async_clear: outs=%b st=%0d expected outs=%b st=0", outs, dbg_state, E_RST);
    else passed++;
    total++;
    if (mem_write !== 1'b0) $display("FAIL midrst_mem_write: mem_write=%b expected 0", mem_write);
    else passed++;
    tick();
    total++;
    if (outs !== E_RST || dbg_state !== 4'd0) $display("FAIL midrst_held: outs=%b st=%0d expected outs=%b st=0", outs, dbg_state, E_RST);
    else passed++;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    total++;
    if (outs !== E_FETCH || dbg_state !== 4'd1) $display("FAIL midrst_recover_fetch: outs=%b st=%0d expected outs=%b st=1", outs, dbg_state, E_FETCH);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    E_RST    = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    E_FETCH  = ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
    E_FWAIT  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
    E_DECODE = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);
    E_MEMADR = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    E_MEMRD  = ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    E_MEMWB  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    E_MEMWR  = ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    E_EXECR  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    E_EXECI  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0);
    E_ALUWB  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    E_BEQ1   = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
    E_BEQ0   = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
    E_JAL    = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0);
    E_TRAP   = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_memwr();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
